// File: rtl/pong_score_ctrl.sv
// Score sequencer for two-player pong: keeps a BCD shadow of both scores, drives the
// external digit counters' inc/clr strobes, and runs the serve/pause/game-over flow.
module pong_score_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       d_clr,
  output logic       inc_l0,
  output logic       inc_l1,
  output logic       inc_r0,
  output logic       inc_r1,
  output logic       ball_en,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    NEWGAME,
    WAIT,
    PLAY,
    SCORE,
    CHECK,
    PAUSE,
    OVER
  } state_t;

  localparam logic [6:0] WIN_VAL   = 7'(WIN_SCORE);
  localparam logic [7:0] PAUSE_LIM = 8'(PAUSE_FRAMES);

  state_t     state;
  logic       btn_start_q;
  logic       scorer_r;
  logic [3:0] l_units, l_tens, r_units, r_tens;
  logic [7:0] pause_cnt;
  logic [6:0] l_val, r_val;
  logic       start_edge;
  logic       scorer_won;

  assign start_edge = btn_start & ~btn_start_q;

  // Binary value of each shadow score, used only for the win comparison.
  always_comb begin
    l_val      = 7'({3'b000, l_tens} * 7'd10) + {3'b000, l_units};
    r_val      = 7'({3'b000, r_tens} * 7'd10) + {3'b000, r_units};
    scorer_won = scorer_r ? (r_val == WIN_VAL) : (l_val == WIN_VAL);
  end

  // Strobes and levels are registered on the edge that enters the state they belong
  // to, so a miss sampled in cycle n shows up as an inc strobe in cycle n+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= NEWGAME;
      btn_start_q <= 1'b0;
      scorer_r    <= 1'b0;
      l_units     <= 4'd0;
      l_tens      <= 4'd0;
      r_units     <= 4'd0;
      r_tens      <= 4'd0;
      pause_cnt   <= 8'd0;
      d_clr       <= 1'b0;
      inc_l0      <= 1'b0;
      inc_l1      <= 1'b0;
      inc_r0      <= 1'b0;
      inc_r1      <= 1'b0;
      ball_en     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      btn_start_q <= btn_start;
      d_clr       <= 1'b0;
      inc_l0      <= 1'b0;
      inc_l1      <= 1'b0;
      inc_r0      <= 1'b0;
      inc_r1      <= 1'b0;

      case (state)
        NEWGAME: begin
          d_clr     <= 1'b1;
          l_units   <= 4'd0;
          l_tens    <= 4'd0;
          r_units   <= 4'd0;
          r_tens    <= 4'd0;
          winner    <= 2'b00;
          game_over <= 1'b0;
          ball_en   <= 1'b0;
          state     <= WAIT;
        end

        WAIT: begin
          if (start_edge) begin
            ball_en <= 1'b1;
            state   <= PLAY;
          end
        end

        PLAY: begin
          // Simultaneous misses cancel out; only a lone miss awards a point.
          if (miss_r && !miss_l) begin
            scorer_r <= 1'b0;
            inc_l0   <= 1'b1;
            inc_l1   <= (l_units == 4'd9);
            l_units  <= (l_units == 4'd9) ? 4'd0 : l_units + 4'd1;
            l_tens   <= (l_units == 4'd9) ? l_tens + 4'd1 : l_tens;
            ball_en  <= 1'b0;
            state    <= SCORE;
          end else if (miss_l && !miss_r) begin
            scorer_r <= 1'b1;
            inc_r0   <= 1'b1;
            inc_r1   <= (r_units == 4'd9);
            r_units  <= (r_units == 4'd9) ? 4'd0 : r_units + 4'd1;
            r_tens   <= (r_units == 4'd9) ? r_tens + 4'd1 : r_tens;
            ball_en  <= 1'b0;
            state    <= SCORE;
          end
        end

        SCORE: begin
          if (scorer_won) begin
            game_over <= 1'b1;
            winner    <= scorer_r ? 2'b10 : 2'b01;
          end
          state <= CHECK;
        end

        CHECK: begin
          if (scorer_won) begin
            state <= OVER;
          end else begin
            pause_cnt <= 8'd0;
            state     <= PAUSE;
          end
        end

        PAUSE: begin
          if (tick) begin
            pause_cnt <= pause_cnt + 8'd1;
            if (pause_cnt + 8'd1 == PAUSE_LIM) begin
              state <= WAIT;
            end
          end
        end

        OVER: begin
          if (start_edge) begin
            game_over <= 1'b0;
            winner    <= 2'b00;
            state     <= NEWGAME;
          end
        end

        default: state <= NEWGAME;
      endcase
    end
  end

endmodule
